button_event_fsm: RTL and testbench
===================================

BUTTON_EVENT_FSM -- requirements
Module: button_event_fsm

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 16: cycles held before a long press; legal range 2..65535.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: maximum release-to-press gap for a double click; legal range 2..65535.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 4: period of repeat pulses after a long press; legal range 2..65535.
REQ-004 SHALL have port clock, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port btn_level, input, 1 bit: debounced button level, already synchronous to clock.
REQ-007 SHALL have port enable, input, 1 bit: low forces the FSM idle and blocks all pulses.
REQ-008 SHALL have ports press_pulse, release_pulse, click_pulse, double_click_pulse, long_press_pulse, repeat_pulse, each output, 1 bit: one-cycle event pulses.
REQ-009 SHALL have port held, output, 1 bit: high while the FSM considers the button pressed.
REQ-010 SHALL have port state_dbg, output, 3 bits: current state encoding, for debug only.

Function
REQ-011 SHALL register btn_level into btn_prev every cycle, regardless of enable; rise = btn_level & ~btn_prev; fall = ~btn_level & btn_prev.
REQ-012 SHALL register all outputs; an event sampled at edge E drives its pulse high from E to E+1 (1-cycle latency); every pulse is exactly one cycle wide.
REQ-013 SHALL implement states IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_GAP=3, SECOND=4; codes 5..7 SHALL return to IDLE with no pulse.
REQ-014 SHALL keep a single timer, 16 bits, cleared on every state transition and incremented by 1 each cycle the state is held; it SHALL never wrap.
REQ-015 IDLE: rise -> PRESSED, press_pulse; fall is ignored.
REQ-016 PRESSED: fall -> WAIT_GAP, release_pulse; otherwise timer==LONG_CYCLES-1 -> LONG_HELD, long_press_pulse. long_press_pulse SHALL occur exactly LONG_CYCLES cycles after press_pulse.
REQ-017 LONG_HELD: fall -> IDLE, release_pulse, no click; otherwise timer==REPEAT_CYCLES-1 -> repeat_pulse and timer cleared (state kept). The first repeat_pulse SHALL occur REPEAT_CYCLES cycles after long_press_pulse, then every REPEAT_CYCLES cycles.
REQ-018 WAIT_GAP: rise -> SECOND, press_pulse; otherwise timer==GAP_CYCLES-1 -> IDLE, click_pulse. click_pulse SHALL occur GAP_CYCLES cycles after release_pulse.
REQ-019 SECOND: fall -> IDLE, release_pulse and double_click_pulse in the same cycle; otherwise timer==LONG_CYCLES-1 -> LONG_HELD, long_press_pulse, and no double click is reported.
REQ-020 Simultaneous events: an edge SHALL win over a timer threshold in the same cycle (fall beats long/repeat; rise beats gap timeout).
REQ-021 SHALL assert held in PRESSED, LONG_HELD and SECOND only.
REQ-022 enable low SHALL force state IDLE and the timer to 0 on the next edge and suppress all pulses; after enable returns high, a level already high SHALL NOT produce press_pulse (only a new rise does).
REQ-023 At most one of click_pulse, double_click_pulse, long_press_pulse SHALL be high in any cycle; repeat_pulse SHALL never coincide with release_pulse.

Reset
REQ-024 SHALL reset state to IDLE, timer to 0, btn_prev to 0, and all outputs to 0, asynchronously; a btn_level already high at reset release SHALL produce press_pulse one cycle later.
REQ-025 Reset asserted mid-sequence SHALL abort it with no pending pulse emitted after release.

Verification (defaults L=16, G=8, R=4; cycle 0 = press_pulse)
REQ-026 Short press: high 5 cycles, then low -> press@0, release@5, click@13, held high 0..4, no other pulses.
REQ-027 Double click: high 3, low 4, high 3, low -> press@0, release@3, press@7, release+double_click@10, no click_pulse.
REQ-028 Long hold: high 30 cycles -> long_press@16, repeat@20,24,28, release@30, no click or double click.
REQ-029 Boundary: fall sampled at timer==15 in PRESSED -> release@16, no long_press, click@24.
REQ-030 enable low at cycle 5 during a press -> all outputs 0 and state_dbg=0 from cycle 6; enable high at cycle 10 with the level still high -> no press_pulse until a new rise.
REQ-031 Reset pulse in LONG_HELD -> all outputs 0 immediately; no repeat or release pulse after reset deasserts while the level stays low.

Source files
------------

// File: rtl/button_event_fsm.sv
// -----------------------------------------------------------------------------
// button_event_fsm
//
// Turns a debounced, clock-synchronous button level into one-cycle event
// pulses: press, release, single click, double click, long press and
// auto-repeat while the button stays held after a long press.
//
// Parameters
//   LONG_CYCLES   cycles held before a long press is reported (2..65535)
//   GAP_CYCLES    longest release-to-press gap that still forms a double
//                 click (2..65535)
//   REPEAT_CYCLES period of repeat pulses once a long press is active
//                 (2..65535)
//
// Ports
//   clock               rising-edge clock
//   reset               asynchronous, active-high reset
//   btn_level           debounced button level, synchronous to clock
//   enable              low forces the FSM idle and blocks every pulse
//   press_pulse         one-cycle pulse on an accepted press
//   release_pulse       one-cycle pulse on an accepted release
//   click_pulse         one-cycle pulse when a single click is confirmed
//   double_click_pulse  one-cycle pulse when a double click completes
//   long_press_pulse    one-cycle pulse when a hold reaches LONG_CYCLES
//   repeat_pulse        one-cycle pulse every REPEAT_CYCLES during a long hold
//   held                high while the FSM considers the button pressed
//   state_dbg           current state encoding, debug only
// -----------------------------------------------------------------------------
module button_event_fsm #(
  parameter int unsigned LONG_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_level,
  input  logic       enable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       double_click_pulse,
  output logic       long_press_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [2:0] state_dbg
);

  // Reject parameter values the 16-bit timer cannot represent.
  generate
    if (LONG_CYCLES < 2 || LONG_CYCLES > 65535) begin : g_bad_long
      $error("button_event_fsm: LONG_CYCLES out of range 2..65535");
    end
    if (GAP_CYCLES < 2 || GAP_CYCLES > 65535) begin : g_bad_gap
      $error("button_event_fsm: GAP_CYCLES out of range 2..65535");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_repeat
      $error("button_event_fsm: REPEAT_CYCLES out of range 2..65535");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    SECOND    = 3'd4
  } state_t;

  // The timer counts cycles spent in the current state starting at 0, so a
  // threshold of N cycles is reached when the timer reads N-1.
  localparam logic [15:0] LONG_LAST   = 16'(LONG_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_CYCLES - 1);
  localparam logic [15:0] TIMER_MAX   = 16'hFFFF;

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic [15:0] timer_next;
  logic        btn_prev;
  logic        rise;
  logic        fall;

  logic        press_next;
  logic        release_next;
  logic        click_next;
  logic        double_next;
  logic        long_next;
  logic        repeat_next;
  logic        held_next;

  assign rise = btn_level & ~btn_prev;
  assign fall = ~btn_level & btn_prev;

  // The previous level is tracked even while disabled, so a button that is
  // already down when enable returns does not look like a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_level;
    end
  end

  // State, timer and all event outputs are registered together; the pulses
  // decided at an edge are visible for exactly the following cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      timer              <= 16'd0;
      press_pulse        <= 1'b0;
      release_pulse      <= 1'b0;
      click_pulse        <= 1'b0;
      double_click_pulse <= 1'b0;
      long_press_pulse   <= 1'b0;
      repeat_pulse       <= 1'b0;
      held               <= 1'b0;
    end else begin
      state              <= state_next;
      timer              <= timer_next;
      press_pulse        <= press_next;
      release_pulse      <= release_next;
      click_pulse        <= click_next;
      double_click_pulse <= double_next;
      long_press_pulse   <= long_next;
      repeat_pulse       <= repeat_next;
      held               <= held_next;
    end
  end

  // Next-state and pulse decode. Within each state the edge test comes
  // first, so a release or a second press always beats a timer threshold
  // that expires in the same cycle.
  always_comb begin
    state_next   = state;
    timer_next   = (timer == TIMER_MAX) ? timer : timer + 16'd1;
    press_next   = 1'b0;
    release_next = 1'b0;
    click_next   = 1'b0;
    double_next  = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    if (!enable) begin
      state_next = IDLE;
      timer_next = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = PRESSED;
            press_next = 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_next   = WAIT_GAP;
            release_next = 1'b1;
          end else if (timer == LONG_LAST) begin
            state_next = LONG_HELD;
            long_next  = 1'b1;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_next   = IDLE;
            release_next = 1'b1;
          end else if (timer == REPEAT_LAST) begin
            repeat_next = 1'b1;
            timer_next  = 16'd0;
          end
        end
        WAIT_GAP: begin
          if (rise) begin
            state_next = SECOND;
            press_next = 1'b1;
          end else if (timer == GAP_LAST) begin
            state_next = IDLE;
            click_next = 1'b1;
          end
        end
        SECOND: begin
          if (fall) begin
            state_next   = IDLE;
            release_next = 1'b1;
            double_next  = 1'b1;
          end else if (timer == LONG_LAST) begin
            state_next = LONG_HELD;
            long_next  = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    if (state_next != state) begin
      timer_next = 16'd0;
    end
  end

  // held follows the state being entered so it lines up with the pulses.
  always_comb begin
    held_next = (state_next == PRESSED) || (state_next == LONG_HELD) ||
                (state_next == SECOND);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_button_event_fsm.sv
// -----------------------------------------------------------------------------
// tb_button_event_fsm
//
// Drives button_event_fsm with directed scenarios and random level/enable/
// reset sequences. A timestamp-based reference model predicts every output
// each cycle; directed scenarios also check event timing offsets.
// -----------------------------------------------------------------------------
module tb_button_event_fsm;

  localparam int L = 16;
  localparam int G = 8;
  localparam int R = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_level;
  logic       enable;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       double_click_pulse;
  logic       long_press_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [2:0] state_dbg;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: remembers when things happened, not a state register.
  bit       m_prev;
  bit       m_active;
  bit       m_second;
  bit       m_long;
  bit       m_wait;
  int       m_press_t;
  int       m_mark_t;
  int       m_rel_t;
  logic [6:0] exp_vec;
  logic [2:0] exp_state;

  // Observed event times for directed offset checks.
  int press_cyc;
  int rel_cyc;
  int click_cyc;
  int dbl_cyc;
  int long_cyc;
  int rep_cyc;
  int rep_count;

  button_event_fsm #(
    .LONG_CYCLES  (L),
    .GAP_CYCLES   (G),
    .REPEAT_CYCLES(R)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .btn_level         (btn_level),
    .enable            (enable),
    .press_pulse       (press_pulse),
    .release_pulse     (release_pulse),
    .click_pulse       (click_pulse),
    .double_click_pulse(double_click_pulse),
    .long_press_pulse  (long_press_pulse),
    .repeat_pulse      (repeat_pulse),
    .held              (held),
    .state_dbg         (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_prev    = 1'b0;
    m_active  = 1'b0;
    m_second  = 1'b0;
    m_long    = 1'b0;
    m_wait    = 1'b0;
    exp_vec   = '0;
    exp_state = 3'd0;
  endtask

  task automatic modelStep(input bit lvl, input bit en);
    bit rise, fall;
    bit p, r, c, d, lp, rp;
    rise = lvl & ~m_prev;
    fall = ~lvl & m_prev;
    {p, r, c, d, lp, rp} = '0;
    if (!en) begin
      m_active = 1'b0;
      m_second = 1'b0;
      m_long   = 1'b0;
      m_wait   = 1'b0;
    end else if (m_active) begin
      if (fall) begin
        r = 1'b1;
        if (!m_long && m_second) d = 1'b1;
        if (!m_long && !m_second) begin
          m_wait  = 1'b1;
          m_rel_t = cyc;
        end
        m_active = 1'b0;
        m_second = 1'b0;
        m_long   = 1'b0;
      end else if (!m_long && (cyc - m_press_t == L)) begin
        lp       = 1'b1;
        m_long   = 1'b1;
        m_mark_t = cyc;
      end else if (m_long && (cyc - m_mark_t == R)) begin
        rp       = 1'b1;
        m_mark_t = cyc;
      end
    end else if (m_wait) begin
      if (rise) begin
        p         = 1'b1;
        m_wait    = 1'b0;
        m_active  = 1'b1;
        m_second  = 1'b1;
        m_long    = 1'b0;
        m_press_t = cyc;
      end else if (cyc - m_rel_t == G) begin
        c      = 1'b1;
        m_wait = 1'b0;
      end
    end else if (rise) begin
      p         = 1'b1;
      m_active  = 1'b1;
      m_second  = 1'b0;
      m_long    = 1'b0;
      m_press_t = cyc;
    end
    exp_vec = {p, r, c, d, lp, rp, m_active};
    if (m_long)                    exp_state = 3'd2;
    else if (m_active && m_second) exp_state = 3'd4;
    else if (m_active)             exp_state = 3'd1;
    else if (m_wait)               exp_state = 3'd3;
    else                           exp_state = 3'd0;
    m_prev = lvl;
  endtask

  task automatic clearMarks();
    press_cyc = -1;
    rel_cyc   = -1;
    click_cyc = -1;
    dbl_cyc   = -1;
    long_cyc  = -1;
    rep_cyc   = -1;
    rep_count = 0;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, then
  // compare every output at the following falling edge.
  task automatic applyStimulus(input bit lvl, input bit en, input int n);
    for (int i = 0; i < n; i++) begin
      btn_level = lvl;
      enable    = en;
      cyc++;
      modelStep(lvl, en);
      @(negedge clock);
      checkOutput("pulses", {press_pulse, release_pulse, click_pulse, double_click_pulse,
                             long_press_pulse, repeat_pulse, held}, exp_vec);
      checkOutput("state_dbg", state_dbg, exp_state);
      if (press_pulse && press_cyc < 0)   press_cyc = cyc;
      if (release_pulse && rel_cyc < 0)   rel_cyc   = cyc;
      if (click_pulse && click_cyc < 0)   click_cyc = cyc;
      if (double_click_pulse)             dbl_cyc   = cyc;
      if (long_press_pulse && long_cyc < 0) long_cyc = cyc;
      if (repeat_pulse) begin
        if (rep_cyc < 0) rep_cyc = cyc;
        rep_count++;
      end
    end
  endtask

  task automatic pulseReset(input bit lvl);
    reset     = 1'b1;
    btn_level = lvl;
    #1;
    checkOutput("reset_outputs", {press_pulse, release_pulse, click_pulse, double_click_pulse,
                                  long_press_pulse, repeat_pulse, held}, 0);
    checkOutput("reset_state", state_dbg, 0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int sel, len;
    bit lvl, en;
    reset     = 1'b1;
    btn_level = 1'b0;
    enable    = 1'b1;
    modelReset();
    clearMarks();
    #1;
    checkOutput("reset_outputs", {press_pulse, release_pulse, click_pulse, double_click_pulse,
                                  long_press_pulse, repeat_pulse, held}, 0);
    checkOutput("reset_state", state_dbg, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 1, 3);

    // Short press.
    clearMarks();
    applyStimulus(1, 1, 5);
    applyStimulus(0, 1, 12);
    checkOutput("short_release_ofs", rel_cyc - press_cyc, 5);
    checkOutput("short_click_ofs", click_cyc - press_cyc, 13);

    // Double click.
    clearMarks();
    applyStimulus(1, 1, 3);
    applyStimulus(0, 1, 4);
    applyStimulus(1, 1, 3);
    applyStimulus(0, 1, 12);
    checkOutput("double_ofs", dbl_cyc - press_cyc, 10);
    checkOutput("double_no_click", click_cyc, -1);

    // Long hold with repeats.
    clearMarks();
    applyStimulus(1, 1, 30);
    applyStimulus(0, 1, 12);
    checkOutput("long_ofs", long_cyc - press_cyc, 16);
    checkOutput("first_repeat_ofs", rep_cyc - press_cyc, 20);
    checkOutput("repeat_count", rep_count, 3);
    checkOutput("long_release_ofs", rel_cyc - press_cyc, 30);
    checkOutput("long_no_click", click_cyc, -1);

    // Release exactly at the long-press threshold.
    clearMarks();
    applyStimulus(1, 1, 16);
    applyStimulus(0, 1, 12);
    checkOutput("edge_release_ofs", rel_cyc - press_cyc, 16);
    checkOutput("edge_no_long", long_cyc, -1);
    checkOutput("edge_click_ofs", click_cyc - press_cyc, 24);

    // Enable dropped mid-press, restored with level still high.
    clearMarks();
    applyStimulus(1, 1, 5);
    applyStimulus(1, 0, 5);
    press_cyc = -1;
    applyStimulus(1, 1, 5);
    checkOutput("enable_no_press", press_cyc, -1);
    applyStimulus(0, 1, 3);
    applyStimulus(1, 1, 3);
    applyStimulus(0, 1, 12);

    // Reset while in long hold.
    applyStimulus(1, 1, 20);
    pulseReset(0);
    clearMarks();
    applyStimulus(0, 1, 15);
    checkOutput("post_reset_no_release", rel_cyc, -1);
    checkOutput("post_reset_no_repeat", rep_count, 0);

    // Level already high at reset release.
    pulseReset(1);
    clearMarks();
    applyStimulus(1, 1, 3);
    checkOutput("reset_high_press", press_cyc >= 0 ? 1 : 0, 1);
    applyStimulus(0, 1, 12);

    // Random sequences.
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        pulseReset(1'($urandom_range(0, 1)));
      end else begin
        lvl = 1'($urandom_range(0, 1));
        en  = ($urandom_range(0, 15) != 0);
        len = $urandom_range(1, 22);
        applyStimulus(lvl, en, len);
      end
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
